// File: rtl/jtag_ir_unit.sv
// JTAG instruction register: capture/shift/update stages plus registered one-hot opcode decode.
// Latency: LATCH_IR and the select outputs update on the same TCK edge as UPDATE_IR; TDO_IR is combinational.
// Backpressure: none; the TAP strobes are obeyed every cycle (RESET/TLR > UPDATE_IR > CAPTURE_IR > SHIFT_IR).
module jtag_ir_unit #(
   parameter int                              IR_WIDTH     = 4,
   parameter int                              NUM_INSTR    = 8,
   parameter logic [NUM_INSTR*IR_WIDTH-1:0]   OPCODES      = 32'h98754321,
   parameter logic [IR_WIDTH-1:0]             RESET_OPCODE = 4'h7
) (
   input  logic                                        TCK,
   input  logic                                        RESET,
   input  logic                                        TLR,
   input  logic                                        CAPTURE_IR,
   input  logic                                        SHIFT_IR,
   input  logic                                        UPDATE_IR,
   input  logic                                        TDI,
   // For IR_WIDTH == 2 there are no status bits; the single port bit is then ignored.
   input  logic [(IR_WIDTH > 2 ? IR_WIDTH-3 : 0):0]    STATUS,
   output logic                                        TDO_IR,
   output logic                                        TDO_EN,
   output logic [IR_WIDTH-1:0]                         LATCH_IR,
   output logic [NUM_INSTR-1:0]                        INSTR_SELECT,
   output logic                                        BYPASS_SELECT
);

   logic [IR_WIDTH-1:0]  sr_q;
   logic [IR_WIDTH-1:0]  cap_val;
   logic [NUM_INSTR:0]   dec_sr;
   logic [NUM_INSTR:0]   dec_rst;

   // Returns {bypass, one-hot select}. The lowest matching table index wins, so duplicate
   // entries never raise two bits. Bypass is simply "no table hit": an all-ones value that
   // is not in the table misses and bypasses, while an all-ones table entry wins over bypass.
   function automatic logic [NUM_INSTR:0] decode(input logic [IR_WIDTH-1:0] val);
      logic [NUM_INSTR-1:0] sel;
      logic                 hit;
      sel = '0;
      hit = 1'b0;
      for (int i = 0; i < NUM_INSTR; i++) begin
         if (!hit && (val == OPCODES[i*IR_WIDTH +: IR_WIDTH])) begin
            sel[i] = 1'b1;
            hit    = 1'b1;
         end
      end
      return {~hit, sel};
   endfunction

   // Capture value: design status in the upper bits, fixed 2'b01 in the two LSBs.
   generate
      if (IR_WIDTH > 2) begin : g_cap_status
         assign cap_val = {STATUS, 2'b01};
      end else begin : g_cap_fixed
         assign cap_val = 2'b01;
      end
   endgenerate

   assign dec_sr  = decode(sr_q);
   assign dec_rst = decode(RESET_OPCODE);
   assign TDO_IR  = sr_q[0];

   // IR pipeline: one strobe acts per edge, highest priority first; no strobe holds everything.
   always_ff @(posedge TCK) begin
      if (RESET || TLR) begin
         sr_q          <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
         LATCH_IR      <= RESET_OPCODE;
         INSTR_SELECT  <= dec_rst[NUM_INSTR-1:0];
         BYPASS_SELECT <= dec_rst[NUM_INSTR];
         TDO_EN        <= 1'b0;
      end else begin
         TDO_EN <= SHIFT_IR;
         if (UPDATE_IR) begin
            LATCH_IR      <= sr_q;
            INSTR_SELECT  <= dec_sr[NUM_INSTR-1:0];
            BYPASS_SELECT <= dec_sr[NUM_INSTR];
         end else if (CAPTURE_IR) begin
            sr_q <= cap_val;
         end else if (SHIFT_IR) begin
            sr_q <= {TDI, sr_q[IR_WIDTH-1:1]};
         end
      end
   end

endmodule

// File: tb/tb_jtag_ir_unit.sv
// Directed bench for jtag_ir_unit: default 4-bit table plus a 6-bit, 3-entry duplicate-table instance.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: n/a; every strobe is applied for exactly one cycle unless stated.
module tb_jtag_ir_unit;

   logic       TCK = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   // Instance A: default parameters
   logic       rst_a, tlr_a, cap_a, sh_a, upd_a, tdi_a;
   logic [1:0] status_a;
   logic       tdo_a, tdo_en_a, byp_a;
   logic [3:0] latch_a;
   logic [7:0] sel_a;

   // Instance B: 6-bit IR, 3 entries with a duplicate
   logic       rst_b, tlr_b, cap_b, sh_b, upd_b, tdi_b;
   logic [3:0] status_b;
   logic       tdo_b, tdo_en_b, byp_b;
   logic [5:0] latch_b;
   logic [2:0] sel_b;

   logic       tdo_seen;

   always #5 TCK = ~TCK;

   jtag_ir_unit dut_a (
      .TCK(TCK), .RESET(rst_a), .TLR(tlr_a), .CAPTURE_IR(cap_a), .SHIFT_IR(sh_a),
      .UPDATE_IR(upd_a), .TDI(tdi_a), .STATUS(status_a), .TDO_IR(tdo_a), .TDO_EN(tdo_en_a),
      .LATCH_IR(latch_a), .INSTR_SELECT(sel_a), .BYPASS_SELECT(byp_a)
   );

   jtag_ir_unit #(
      .IR_WIDTH(6), .NUM_INSTR(3), .OPCODES({6'h05, 6'h05, 6'h21}), .RESET_OPCODE(6'h3F)
   ) dut_b (
      .TCK(TCK), .RESET(rst_b), .TLR(tlr_b), .CAPTURE_IR(cap_b), .SHIFT_IR(sh_b),
      .UPDATE_IR(upd_b), .TDI(tdi_b), .STATUS(status_b), .TDO_IR(tdo_b), .TDO_EN(tdo_en_b),
      .LATCH_IR(latch_b), .INSTR_SELECT(sel_b), .BYPASS_SELECT(byp_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle on A; tdo_seen holds TDO_IR just before the rising edge.
   task automatic cyc_a(input logic rst, tlr, cap, sh, upd, tdi);
      @(negedge TCK);
      rst_a = rst; tlr_a = tlr; cap_a = cap; sh_a = sh; upd_a = upd; tdi_a = tdi;
      #1 tdo_seen = tdo_a;
      @(posedge TCK);
      #1;
   endtask

   task automatic cyc_b(input logic rst, tlr, cap, sh, upd, tdi);
      @(negedge TCK);
      rst_b = rst; tlr_b = tlr; cap_b = cap; sh_b = sh; upd_b = upd; tdi_b = tdi;
      @(posedge TCK);
      #1;
   endtask

   task automatic load_a(input logic [3:0] v);
      for (int i = 0; i < 4; i++) cyc_a(0, 0, 0, 1, 0, v[i]);
      cyc_a(0, 0, 0, 0, 1, 0);
   endtask

   task automatic load_b(input logic [5:0] v);
      for (int i = 0; i < 6; i++) cyc_b(0, 0, 0, 1, 0, v[i]);
      cyc_b(0, 0, 0, 0, 1, 0);
   endtask

   // Directed sequence covering reset, EXTEST load, unmatched opcodes, priority and the sweep.
   initial begin
      logic [3:0] tdi_seq;
      logic [3:0] tdo_exp;
      rst_a = 1; tlr_a = 0; cap_a = 0; sh_a = 0; upd_a = 0; tdi_a = 0; status_a = 2'b00;
      rst_b = 1; tlr_b = 0; cap_b = 0; sh_b = 0; upd_b = 0; tdi_b = 0; status_b = 4'h0;

      // Reset
      cyc_a(1, 0, 0, 0, 0, 0);
      chk("rst_latch", latch_a, 4'h7);
      chk("rst_sel", sel_a, 8'b0010_0000);
      chk("rst_byp", byp_a, 1'b0);
      chk("rst_tdo_en", tdo_en_a, 1'b0);
      chk("rst_sr", dut_a.sr_q, 4'b0001);
      chk("rst_tdo", tdo_a, 1'b1);

      // Capture-shift-update EXTEST
      status_a = 2'b10;
      cyc_a(0, 0, 1, 0, 0, 0);
      chk("cap_sr", dut_a.sr_q, 4'b1001);
      tdi_seq = 4'b0010;  // TDI 0,1,0,0 LSB first
      tdo_exp = 4'b1001;  // TDO 1,0,0,1
      for (int i = 0; i < 4; i++) begin
         cyc_a(0, 0, 0, 1, 0, tdi_seq[i]);
         chk($sformatf("ext_tdo%0d", i), tdo_seen, tdo_exp[i]);
      end
      chk("ext_tdo_en", tdo_en_a, 1'b1);
      chk("ext_latch_hold", latch_a, 4'h7);
      cyc_a(0, 0, 0, 0, 1, 0);
      chk("ext_latch", latch_a, 4'h2);
      chk("ext_sel", sel_a, 8'b0000_0010);
      chk("ext_byp", byp_a, 1'b0);
      chk("ext_tdo_en_off", tdo_en_a, 1'b0);

      // Unmatched opcodes
      load_a(4'h6);
      chk("u6_latch", latch_a, 4'h6);
      chk("u6_sel", sel_a, 8'h00);
      chk("u6_byp", byp_a, 1'b1);
      load_a(4'hF);
      chk("uf_latch", latch_a, 4'hF);
      chk("uf_sel", sel_a, 8'h00);
      chk("uf_byp", byp_a, 1'b1);

      // Priority: capture beats shift
      status_a = 2'b11;
      cyc_a(0, 0, 1, 1, 0, 0);
      chk("pri_cap_sr", dut_a.sr_q, 4'b1101);
      cyc_a(0, 0, 0, 0, 0, 0);
      chk("idle_sr", dut_a.sr_q, 4'b1101);
      chk("idle_latch", latch_a, 4'hF);
      // TLR beats update
      cyc_a(0, 1, 0, 0, 1, 0);
      chk("pri_tlr_latch", latch_a, 4'h7);
      chk("pri_tlr_sel", sel_a, 8'b0010_0000);
      chk("pri_tlr_sr", dut_a.sr_q, 4'b0001);
      // Update beats capture: SR must keep 0001, not take 1101
      cyc_a(0, 0, 1, 0, 1, 0);
      chk("pri_upd_latch", latch_a, 4'h1);
      chk("pri_upd_sr", dut_a.sr_q, 4'b0001);

      // Reset mid-shift
      cyc_a(0, 0, 1, 0, 0, 0);
      cyc_a(0, 0, 0, 1, 0, 1);
      cyc_a(0, 0, 0, 1, 0, 0);
      cyc_a(0, 1, 0, 1, 0, 1);
      chk("mid_latch", latch_a, 4'h7);
      chk("mid_sr", dut_a.sr_q, 4'b0001);
      chk("mid_tdo_en", tdo_en_a, 1'b0);
      cyc_a(0, 0, 0, 0, 1, 0);
      chk("mid_upd_latch", latch_a, 4'h1);
      chk("mid_upd_sel", sel_a, 8'b0000_0001);
      chk("mid_upd_byp", byp_a, 1'b0);

      // SHIFT_IR held with no update leaves the active instruction alone
      for (int i = 0; i < 5; i++) cyc_a(0, 0, 0, 1, 0, 1);
      chk("hold_latch", latch_a, 4'h1);
      chk("hold_sel", sel_a, 8'b0000_0001);
      chk("hold_sr", dut_a.sr_q, 4'b1111);
      cyc_a(0, 0, 0, 0, 0, 0);

      // Parameter sweep instance
      cyc_b(1, 0, 0, 0, 0, 0);
      chk("b_rst_latch", latch_b, 6'h3F);
      chk("b_rst_sel", sel_b, 3'b000);
      chk("b_rst_byp", byp_b, 1'b1);
      chk("b_rst_sr", dut_b.sr_q, 6'b000001);
      status_b = 4'hA;
      cyc_b(0, 0, 1, 0, 0, 0);
      chk("b_cap_sr", dut_b.sr_q, 6'b101001);
      load_b(6'h05);
      chk("b_dup_latch", latch_b, 6'h05);
      chk("b_dup_sel", sel_b, 3'b010);
      chk("b_dup_byp", byp_b, 1'b0);
      load_b(6'h21);
      chk("b_21_sel", sel_b, 3'b001);
      chk("b_21_byp", byp_b, 1'b0);
      load_b(6'h3F);
      chk("b_3f_sel", sel_b, 3'b000);
      chk("b_3f_byp", byp_b, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
